// File: rtl/sys_sorter_pkg.sv
// Shared types and key ordering for the systolic sorter.
// SYS_SORTER_DESCEND_EN selects largest-first ordering.
package sys_sorter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    READ
  } state_t;

`ifdef SYS_SORTER_DESCEND_EN
  localparam bit DESCEND = 1'b1;
`else
  localparam bit DESCEND = 1'b0;
`endif

  // Strict ordering only: ties never displace a resident key.
  function automatic logic precedes(
    input logic lt,
    input logic gt
  );
    return DESCEND ? gt : lt;
  endfunction

endpackage

// File: rtl/sort_cell.sv
// One compare/store/pass cell of the systolic sorter.
// Ordering follows SYS_SORTER_DESCEND_EN via sys_sorter_pkg.
module sort_cell
  import sys_sorter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic             xv_in,
  input  logic             shift,
  input  logic [WIDTH-1:0] shift_key,
  input  logic             shift_occ,
  output logic [WIDTH-1:0] key,
  output logic             occ,
  output logic [WIDTH-1:0] x,
  output logic             xv
);

  logic take;

  assign take = occ && precedes(x_in < key, x_in > key);

  // Insert, swap or forward an arriving key; shift toward cell 0 on readout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key <= '0;
      occ <= 1'b0;
      x   <= '0;
      xv  <= 1'b0;
    end else if (shift) begin
      key <= shift_key;
      occ <= shift_occ;
      xv  <= 1'b0;
    end else begin
      xv <= 1'b0;
      if (xv_in) begin
        unique case (1'b1)
          !occ: begin
            key <= x_in;
            occ <= 1'b1;
          end
          take: begin
            key <= x_in;
            x   <= key;
            xv  <= 1'b1;
          end
          default: begin
            x  <= x_in;
            xv <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/systolic_sorter.sv
// Linear systolic insertion sorter with flush-triggered readout.
// Define SYS_SORTER_DESCEND_EN for largest-first output.
module systolic_sorter
  import sys_sorter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNTW-1:0]  count,
  output logic             busy
);

  state_t state;

  logic [WIDTH-1:0] key  [DEPTH];
  logic [WIDTH-1:0] xd   [DEPTH];
  logic [WIDTH-1:0] xin  [DEPTH];
  logic [WIDTH-1:0] shk  [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] xv;
  logic [DEPTH-1:0] xvin;
  logic [DEPTH-1:0] sho;

  logic accept;
  logic take;

  assign in_ready = (state == IDLE || state == LOAD)
                  && (count < CNTW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign out_valid = (state == READ) && occ[0];
  assign out_data  = (state == READ) ? key[0] : '0;
  assign take     = out_valid && out_ready;
  assign busy     = (state == DRAIN) || (state == READ);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    if (i == 0) begin : g_head
      assign xin[i]  = in_data;
      assign xvin[i] = accept;
    end else begin : g_body
      assign xin[i]  = xd[i-1];
      assign xvin[i] = xv[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign shk[i] = '0;
      assign sho[i] = 1'b0;
    end else begin : g_next
      assign shk[i] = key[i+1];
      assign sho[i] = occ[i+1];
    end

    sort_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .x_in     (xin[i]),
      .xv_in    (xvin[i]),
      .shift    (take),
      .shift_key(shk[i]),
      .shift_occ(sho[i]),
      .key      (key[i]),
      .occ      (occ[i]),
      .x        (xd[i]),
      .xv       (xv[i])
    );
  end

  // Batch sequencing and held-key count, including keys still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      unique case (state)
        IDLE:  if (accept) state <= LOAD;
        LOAD:  if (flush) state <= DRAIN;
        DRAIN: if (xv == '0) state <= READ;
        READ:  if (take && count == CNTW'(1)) state <= IDLE;
        default: state <= IDLE;
      endcase
      unique case (1'b1)
        accept:  count <= count + CNTW'(1);
        take:    count <= count - CNTW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_sorter.sv
// Directed self-checking bench for systolic_sorter (DEPTH=8, WIDTH=32).
// Expected orders follow SYS_SORTER_DESCEND_EN when defined.
module tb_systolic_sorter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [3:0]  count;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic [31:0] rd [16];
  int          rd_n;

  systolic_sorter dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] k, input logic fl);
    int n = 0;
    in_data  = k;
    in_valid = 1'b1;
    flush    = fl;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL push_timeout key=%0d in_ready=%b want 1", k, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic read_keys(input int n);
    int c = 0;
    rd_n = 0;
    out_ready = 1'b1;
    while (rd_n < n && c < 80) begin
      if (out_valid) begin
        rd[rd_n] = out_data;
        rd_n++;
      end
      @(negedge clk);
      c++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (out_data !== 32'd0) begin
      bad++; $display("FAIL rst_out_data got=%0d want=0", out_data);
    end
    total++;
    if (count !== 4'd0) begin
      bad++; $display("FAIL rst_count got=%0d want=0", count);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_sort();
    logic [31:0] in_k [8];
    logic [31:0] ex [8];
    in_k = '{10, 24, 6, 7, 3, 1, 100, 6};
`ifdef SYS_SORTER_DESCEND_EN
    ex = '{100, 24, 10, 7, 6, 6, 3, 1};
`else
    ex = '{1, 3, 6, 6, 7, 10, 24, 100};
`endif
    for (int i = 0; i < 8; i++) push(in_k[i], 1'b0);
    total++;
    if (count !== 4'd8) begin
      bad++; $display("FAIL sort_count_full got=%0d want=8", count);
    end
    pulse_flush();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL sort_busy got=%b want=1", busy);
    end
    read_keys(8);
    total++;
    if (rd_n != 8) begin
      bad++; $display("FAIL sort_read_n got=%0d want=8", rd_n);
    end
    for (int i = 0; i < rd_n; i++) begin
      total++;
      if (rd[i] !== ex[i]) begin
        bad++; $display("FAIL sort_key%0d got=%0d want=%0d", i, rd[i], ex[i]);
      end
    end
    total++;
    if (count !== 4'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL sort_idle count=%0d busy=%b in_ready=%b want 0,0,1",
               count, busy, in_ready);
    end
  endtask

  task automatic test_full();
    logic [31:0] ex [8];
`ifdef SYS_SORTER_DESCEND_EN
    ex = '{8, 7, 6, 5, 4, 3, 2, 1};
`else
    ex = '{1, 2, 3, 4, 5, 6, 7, 8};
`endif
    for (int i = 0; i < 8; i++) push(32'(8 - i), 1'b0);
    in_data  = 32'd42;
    in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL full_in_ready got=%b want=0", in_ready);
    end
    pulse_flush();
    read_keys(8);
    total++;
    if (rd_n != 8) begin
      bad++; $display("FAIL full_read_n got=%0d want=8", rd_n);
    end
    for (int i = 0; i < rd_n; i++) begin
      total++;
      if (rd[i] !== ex[i]) begin
        bad++; $display("FAIL full_key%0d got=%0d want=%0d", i, rd[i], ex[i]);
      end
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL full_reopen got=%b want=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (count !== 4'd1) begin
      bad++; $display("FAIL full_ninth_count got=%0d want=1", count);
    end
    pulse_flush();
    read_keys(1);
    total++;
    if (rd_n != 1 || rd[0] !== 32'd42) begin
      bad++; $display("FAIL full_ninth n=%0d key=%0d want 1,42", rd_n, rd[0]);
    end
    total++;
    if (count !== 4'd0) begin
      bad++; $display("FAIL full_end_count got=%0d want=0", count);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ex [4];
    logic [31:0] held;
    logic        stalled;
    int          got;
`ifdef SYS_SORTER_DESCEND_EN
    ex = '{9, 6, 5, 3};
`else
    ex = '{3, 5, 6, 9};
`endif
    push(9, 1'b0);
    push(6, 1'b0);
    push(5, 1'b0);
    push(3, 1'b1);
    for (int c = 0; c < 40 && !out_valid; c++) @(negedge clk);
    got = 0;
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (stalled) begin
        total++;
        if (out_data !== held || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL stall_hold got=%0d v=%b want=%0d v=1",
                   out_data, out_valid, held);
        end
      end
      out_ready = (c % 2 == 0);
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          total++;
          if (out_data !== ex[got]) begin
            bad++;
            $display("FAIL stall_key%0d got=%0d want=%0d",
                     got, out_data, ex[got]);
          end
          got++;
        end else begin
          held = out_data;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    total++;
    if (got != 4 || count !== 4'd0) begin
      bad++; $display("FAIL stall_done got=%0d count=%0d want 4,0", got, count);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] ex [2];
    logic [31:0] ex2 [2];
`ifdef SYS_SORTER_DESCEND_EN
    ex  = '{50, 40};
    ex2 = '{2, 1};
`else
    ex  = '{10, 20};
    ex2 = '{1, 2};
`endif
    push(50, 1'b0);
    push(40, 1'b0);
    push(30, 1'b0);
    push(20, 1'b0);
    push(10, 1'b0);
    pulse_flush();
    read_keys(2);
    total++;
    if (rd_n != 2 || rd[0] !== ex[0] || rd[1] !== ex[1]) begin
      bad++;
      $display("FAIL mid_first2 got=%0d,%0d want=%0d,%0d",
               rd[0], rd[1], ex[0], ex[1]);
    end
    total++;
    if (count !== 4'd3) begin
      bad++; $display("FAIL mid_count got=%0d want=3", count);
    end
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset v=%b count=%0d in_ready=%b want 0,0,1",
               out_valid, count, in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push(2, 1'b0);
    push(1, 1'b0);
    pulse_flush();
    read_keys(2);
    total++;
    if (rd_n != 2 || rd[0] !== ex2[0] || rd[1] !== ex2[1]) begin
      bad++;
      $display("FAIL mid_newbatch got=%0d,%0d want=%0d,%0d",
               rd[0], rd[1], ex2[0], ex2[1]);
    end
  endtask

  task automatic test_ties();
    logic [31:0] in_k [5];
    logic [31:0] ex [5];
    in_k = '{5, 2, 5, 9, 5};
`ifdef SYS_SORTER_DESCEND_EN
    ex = '{9, 5, 5, 5, 2};
`else
    ex = '{2, 5, 5, 5, 9};
`endif
    for (int i = 0; i < 5; i++) push(in_k[i], 1'b0);
    pulse_flush();
    read_keys(5);
    total++;
    if (rd_n != 5) begin
      bad++; $display("FAIL ties_read_n got=%0d want=5", rd_n);
    end
    for (int i = 0; i < rd_n; i++) begin
      total++;
      if (rd[i] !== ex[i]) begin
        bad++; $display("FAIL ties_key%0d got=%0d want=%0d", i, rd[i], ex[i]);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_sort();
    test_full();
    test_stall();
    test_reset_mid_read();
    test_ties();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_sorter.md
# systolic_sorter

Parametrised linear systolic sorter for WORD-wide unsigned keys, DEPTH cells deep. Keys stream in through a valid/ready port and insertion-sort themselves as they ripple down a chain of compare-and-swap cells. A `flush` command drains in-flight keys, then shifts the sorted contents out through a second valid/ready port. It replaces hand-chained single PEs at the sorting front end of the systolic array.

## Interface
- `WIDTH`, 32, key width in bits (unsigned compare)
- `DEPTH`, 8, number of cells = maximum keys per batch (≥2)
- `CNTW`, $clog2(DEPTH+1), width of `count`
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-low
- `in_valid` in 1 — key offered
- `in_data` in WIDTH — key
- `in_ready` out 1 — key accepted when `in_valid && in_ready`
- `flush` in 1 — single-cycle request to end the batch and start readout
- `out_valid` out 1 — sorted key available
- `out_data` out WIDTH — sorted key
- `out_ready` in 1 — consumer takes key when `out_valid && out_ready`
- `count` out CNTW — keys currently held, including in-flight keys
- `busy` out 1 — high in DRAIN or READ

## Operation
- Each cell holds `key`, `occ` (occupied), and a registered pass-through `x`/`xv` feeding the next cell. Cell 0's pass-through is the accepted input.
- Cell rule per cycle when `xv`:
  - empty cell: store x; pass nothing.
  - x strictly precedes key: store x; pass old key.
  - otherwise: pass x.
  - Ties pass onward, so the sort is stable (earlier key is emitted first).
- Occupied cells are always contiguous from cell 0. A passed key never leaves cell DEPTH-1 because `count` ≤ DEPTH.
- FSM states:
  - IDLE: `count`==0. Accept input, then go to LOAD. `flush` is ignored.
  - LOAD: accept input while `count` < DEPTH. `flush` goes to DRAIN.
  - DRAIN: `in_ready`=0. When every `xv` is 0, go to READ.
  - READ: `out_valid`=cell 0 `occ`, `out_data`=cell 0 `key`. On handshake all cells shift toward cell 0, cell DEPTH-1 becomes empty, and `count` decrements. When the last key is taken, go to IDLE.
- `in_ready` = (IDLE or LOAD) && `count` < DEPTH.
- `in_valid` handshake and `flush` in the same cycle: the key is included in the batch, then DRAIN.
- Full array (`count`==DEPTH): `in_ready`=0 and the key is held off. No data is lost and no error is raised.
- Reset (any time, including mid-READ) clears all `occ`/`xv`, returns to IDLE, and discards the batch.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `count`=0, `busy`=0.
- A key advances one cell per cycle. It is at rest at most DEPTH-1 cycles after acceptance.
- DRAIN length is 1 to DEPTH cycles. READ is entered the cycle after all `xv` are clear.
- Readout: one key per cycle while `out_ready` stays high. `out_data` and `out_valid` are registered and stay stable while `out_ready`=0.
- `count` updates the cycle after a handshake.

## Configuration
- `SYS_SORTER_DESCEND_EN`:
  - Defined: "precedes" means strictly greater, and output is largest-first.
  - Undefined: strictly less, and output is smallest-first.
- Tie stability holds in both cases.

## Structure
- `sys_sorter_pkg`: FSM state enum typedef (IDLE, LOAD, DRAIN, READ).
- `sys_sorter_pkg` also holds the compare function selected by `SYS_SORTER_DESCEND_EN`.
- Sub-module `sort_cell` (WIDTH): one compare/store/pass cell with a shift-in port for READ.
- The top generates DEPTH instances of `sort_cell` plus the FSM and counter.

## Test plan
- DEPTH=8: input 10,24,6,7,3,1,100,6, then `flush`, `out_ready`=1 -> output 1,3,6,6,7,10,24,100; then IDLE, `count`=0.
- `SYS_SORTER_DESCEND_EN` with the same stimulus -> output 100,24,10,7,6,6,3,1.
- Offer 9 keys to DEPTH=8 -> `in_ready` drops after the 8th. The 9th is accepted only after readout completes and is the sole key of the next batch.
- Input 9,6,5,3 with `flush` asserted together with key 3, then `out_ready` toggled 1,0,1,0… -> output 3,5,6,9. Data is held stable during stalls.
- Reset asserted mid-READ after 2 of 5 keys are read -> `out_valid`=0, `count`=0, `in_ready`=1. A new batch of 2,1 then reads 1,2.
- Key tagging via LSBs with equal keys 5,5,5 -> emitted in arrival order.
